// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding and the HALT instruction returned for unloaded fetch addresses.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    ERROR   = 3'd4
  } boot_state_t;

  localparam logic [5:0]  OPC_HALT   = 6'b111111;
  localparam logic [31:0] HALT_INSTR = {OPC_HALT, 26'd0};

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: synchronous write port for the loader,
// asynchronous read port for the single-cycle core's fetch. Not reset.
module imem_array #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // Write one program word per accepted loader transfer.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction store plus boot loader for the single-cycle core.
// After reset it accepts a program over a valid/ready stream, holds the core
// in reset while loading, then releases it RELEASE_DLY+1 cycles after the last
// word. Fetch is combinational; addresses not yet loaded return HALT_INSTR.
// Optional feature macro: BOOT_CSUM_EN (XOR checksum of the program compared
// against exp_csum on the last word; mismatch parks the loader in ERROR).
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int RELEASE_DLY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic [31:0]       exp_csum,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              core_resetn,
  output logic              boot_done,
  output logic              overflow_err,
  output logic              csum_err,
  output boot_state_t       state_dbg
);

  localparam int REL_W = (RELEASE_DLY < 1) ? 1 : $clog2(RELEASE_DLY + 1);
  localparam logic [ADDR_W:0]  LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [REL_W-1:0] REL_END  = REL_W'(RELEASE_DLY);

  boot_state_t      state;
  logic [ADDR_W:0]  count;
  logic [REL_W-1:0] rel_cnt;
  logic             xfer;
  logic [31:0]      rd_data;

  // Handshake: a word moves when load_valid && load_ready on a rising edge.
  // load_ready is registered and high only in LOAD; load_valid may be
  // dropped at any time, and data/last are only looked at on a transfer.
  assign xfer = load_valid && load_ready;

`ifdef BOOT_CSUM_EN
  logic [31:0] csum_acc;
`else
  // exp_csum has no consumer without the checksum feature.
  logic unused_exp_csum;
  assign unused_exp_csum = ^exp_csum;
  assign csum_err        = 1'b0;
`endif

  // Boot FSM with its counters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      count        <= '0;
      rel_cnt      <= '0;
      load_ready   <= 1'b0;
      core_resetn  <= 1'b0;
      boot_done    <= 1'b0;
      overflow_err <= 1'b0;
`ifdef BOOT_CSUM_EN
      csum_acc     <= '0;
      csum_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state      <= LOAD;
          load_ready <= 1'b1;
        end
        LOAD: begin
          if (xfer) begin
            count <= count + 1'b1;
`ifdef BOOT_CSUM_EN
            csum_acc <= csum_acc ^ load_data;
`endif
            if (load_last) begin
              load_ready <= 1'b0;
              state      <= RELEASE;
`ifdef BOOT_CSUM_EN
              // The last word itself is folded in here, not from csum_acc.
              if ((csum_acc ^ load_data) != exp_csum) begin
                csum_err <= 1'b1;
                state    <= ERROR;
              end
`endif
            end else if (count == LAST_IDX) begin
              // Memory is full and the program still claims more words.
              load_ready   <= 1'b0;
              overflow_err <= 1'b1;
              state        <= ERROR;
            end
          end
        end
        RELEASE: begin
          if (rel_cnt == REL_END) begin
            state       <= RUN;
            core_resetn <= 1'b1;
            boot_done   <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        RUN:     state <= RUN;
        ERROR:   state <= ERROR;
        default: state <= ERROR;
      endcase
    end
  end

  imem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .clk   (clk),
    .we    (xfer),
    .waddr (count[ADDR_W-1:0]),
    .wdata (load_data),
    .raddr (fetch_addr),
    .rdata (rd_data)
  );

  // Only words written since the last reset are visible to the core.
  assign fetch_instr = ({1'b0, fetch_addr} < count) ? rd_data : HALT_INSTR;
  assign state_dbg   = state;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: table of fetch vectors per phase plus
// hand-written sequences for load, overflow, gapped valid and resets.
module tb_imem_boot_loader;
  import boot_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RDLY  = 2;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic          clk;
  logic          resetn;
  logic          load_valid;
  logic          load_ready;
  logic [31:0]   load_data;
  logic          load_last;
  logic [31:0]   exp_csum;
  logic [AW-1:0] fetch_addr;
  logic [31:0]   fetch_instr;
  logic          core_resetn;
  logic          boot_done;
  logic          overflow_err;
  logic          csum_err;
  boot_state_t   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            phase;
    logic [AW-1:0] addr;
    logic [31:0]   exp_instr;
  } fvec_t;

  fvec_t       vecs[$];
  logic [31:0] exp_q[$];

  imem_boot_loader #(
    .DEPTH       (DEPTH),
    .ADDR_W      (AW),
    .RELEASE_DLY (RDLY)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_last    (load_last),
    .exp_csum     (exp_csum),
    .fetch_addr   (fetch_addr),
    .fetch_instr  (fetch_instr),
    .core_resetn  (core_resetn),
    .boot_done    (boot_done),
    .overflow_err (overflow_err),
    .csum_err     (csum_err),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_fetch(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    fetch_addr = a;
    #1;
    check(name, fetch_instr, exp);
  endtask

  task automatic run_fetch(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph)
        check_fetch($sformatf("fetch_p%0d_a%0d", ph, vecs[i].addr), vecs[i].addr, vecs[i].exp_instr);
    end
  endtask

  // Assert reset between clock edges, check the asynchronous effect, then
  // release and follow IDLE -> LOAD.
  task automatic do_reset();
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_core_resetn", core_resetn, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_boot_done", boot_done, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_csum", csum_err, 0);
    check("rst_state", state_dbg, IDLE);
    check_fetch("rst_fetch0", '0, HALT);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("idle_after_release", state_dbg, IDLE);
    @(posedge clk);
    #1;
    check("load_state", state_dbg, LOAD);
    check("load_ready_in_load", load_ready, 1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [31:0] cs);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    exp_csum   = cs;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_run(input string name, input int budget);
    int n;
    n = 0;
    while (boot_done !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, boot_done, 1);
  endtask

  initial begin
    logic [31:0] prog[4];
    logic        pat[5];
    logic [31:0] gw[3];
    int          w;

    resetn     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    exp_csum   = '0;
    fetch_addr = '0;

    prog = '{32'h9000_000A, 32'h9001_0004, 32'h0401_17FF, 32'hFC00_0000};
    pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    gw   = '{32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3};

    // Fetch vectors: {phase, address, expected instruction}
    vecs.push_back('{1, 4'd0,  32'h9000_000A});
    vecs.push_back('{1, 4'd2,  32'h0401_17FF});
    vecs.push_back('{1, 4'd3,  32'hFC00_0000});
    vecs.push_back('{1, 4'd4,  HALT});
    vecs.push_back('{1, 4'd7,  HALT});
    vecs.push_back('{2, 4'd0,  32'h1000_0000});
    vecs.push_back('{2, 4'd8,  32'h1000_0008});
    vecs.push_back('{2, 4'd15, 32'h1000_000F});
    vecs.push_back('{3, 4'd3,  HALT});
    vecs.push_back('{3, 4'd15, HALT});
    vecs.push_back('{4, 4'd0,  32'h1234_5678});
    vecs.push_back('{4, 4'd1,  HALT});

    // Program load, back-to-back, exact release latency
    do_reset();
    for (int i = 0; i < 4; i++) send_word(prog[i], (i == 3), '0);
    check("pl_ready_low", load_ready, 0);
    check("pl_state_release", state_dbg, RELEASE);
    check("pl_core_held", core_resetn, 0);
    for (int k = 1; k <= RDLY + 1; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("pl_core_resetn_e%0d", k), core_resetn, 32'(k == RDLY + 1));
      check($sformatf("pl_boot_done_e%0d", k), boot_done, 32'(k == RDLY + 1));
    end
    // Loader input in RUN must be ignored.
    for (int i = 0; i < 2; i++) send_word(32'h5555_0000 + i, 1'b0, '0);
    check("run_ready_low", load_ready, 0);
    check("run_state", state_dbg, RUN);
    run_fetch(1);

    // Overflow: 16 words, never last
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      send_word(32'h1000_0000 + i, 1'b0, '0);
      if (i == DEPTH - 2) begin
        check("ov_not_yet", overflow_err, 0);
        check("ov_still_load", state_dbg, LOAD);
      end
    end
    check("ov_err", overflow_err, 1);
    check("ov_ready_low", load_ready, 0);
    check("ov_state", state_dbg, ERROR);
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    load_last  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("ov_core_held_%0d", i), core_resetn, 0);
    end
    check("ov_ready_still_low", load_ready, 0);
    load_valid = 1'b0;
    run_fetch(2);

    // Gapped valid: 1,0,1,0,1 with ignored garbage on idle cycles
    do_reset();
    exp_q.delete();
    w = 0;
    for (int j = 0; j < 5; j++) begin
      load_valid = pat[j];
      load_data  = pat[j] ? gw[w] : 32'hBAD0_0000;
      load_last  = (j == 4) || !pat[j];
      if (pat[j]) begin
        exp_q.push_back(gw[w]);
        w++;
      end
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    wait_run("gap_reaches_run", 10);
    for (int i = 0; i < 3; i++)
      check_fetch($sformatf("gap_fetch_%0d", i), AW'(i), exp_q.pop_front());
    run_fetch(3);

    // Reset mid-load discards the partial program
    do_reset();
    send_word(32'h1111_1111, 1'b0, '0);
    send_word(32'h2222_2222, 1'b0, '0);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_core_low", core_resetn, 0);
    check("mid_ready_low_async", load_ready, 0);
    check_fetch("mid_fetch0_halt", '0, HALT);
    do_reset();
    send_word(32'h1234_5678, 1'b1, '0);
    wait_run("reload_reaches_run", 10);
    check("reload_core_released", core_resetn, 1);
    run_fetch(4);

    // Reset during RUN: do_reset checks the asynchronous drop and IDLE->LOAD
    check("prerun_boot_done", boot_done, 1);
    do_reset();

`ifdef BOOT_CSUM_EN
    send_word(32'h1, 1'b0, 32'h7);
    send_word(32'h2, 1'b0, 32'h7);
    send_word(32'h4, 1'b1, 32'h7);
    wait_run("csum_match_run", 10);
    check("csum_match_no_err", csum_err, 0);
    do_reset();
    send_word(32'h1, 1'b0, 32'h6);
    send_word(32'h2, 1'b0, 32'h6);
    send_word(32'h4, 1'b1, 32'h6);
    check("csum_err_set", csum_err, 1);
    check("csum_state_error", state_dbg, ERROR);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("csum_core_held_%0d", i), core_resetn, 0);
    end
`else
    // Without the checksum feature a wrong exp_csum must not matter.
    send_word(32'h1, 1'b0, 32'h6);
    send_word(32'h2, 1'b0, 32'h6);
    send_word(32'h4, 1'b1, 32'h6);
    wait_run("nocsum_run", 10);
    check("nocsum_err_zero", csum_err, 0);
    check("nocsum_core", core_resetn, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle processor core: instruction store plus boot loader.
- After reset it accepts a program as a valid/ready word stream and writes it into instruction memory.
- While loading, it holds the core in reset. It releases the core only after the program has loaded cleanly.
- It then serves combinational instruction fetches to the core.

Parameters:
- DEPTH, 16: instruction memory depth in 32-bit words; power of two, ≥2.
- ADDR_W, $clog2(DEPTH): fetch word-address width.
- RELEASE_DLY, 2: cycles spent in RELEASE before core_resetn rises; ≥1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- load_valid  in  1  loader word valid.
- load_ready  out  1  loader may transfer this cycle.
- load_data  in  32  program word.
- load_last  in  1  marks final program word.
- exp_csum  in  32  expected XOR checksum; used only with BOOT_CSUM_EN.
- fetch_addr  in  ADDR_W  core word address (PC word index).
- fetch_instr  out  32  instruction at fetch_addr.
- core_resetn  out  1  registered active-low reset to the core.
- boot_done  out  1  high in RUN.
- overflow_err  out  1  sticky; program longer than DEPTH.
- csum_err  out  1  sticky; checksum mismatch.

Behaviour:
- Reset is asynchronous and active-low. Asserting resetn immediately forces:
  - state=IDLE, word count=0, release counter=0, checksum accumulator=0.
  - load_ready=0, core_resetn=0, boot_done=0, overflow_err=0, csum_err=0.
- Memory contents are not cleared by reset.
- Word count is ADDR_W+1 bits wide, range 0..DEPTH.
- State machine, one-hot or encoded:
  - IDLE: lasts one cycle after resetn deasserts, then moves to LOAD.
  - LOAD: load_ready=1. A transfer occurs when load_valid && load_ready. On a transfer, mem[count]←load_data and count++.
    - Transfer with load_last=1 → RELEASE (load_ready=0 from the next cycle).
    - Transfer with load_last=0 while count==DEPTH-1 → the word is written, overflow_err←1, state → ERROR.
    - load_valid=0 → hold state, no write.
  - RELEASE: counts RELEASE_DLY cycles, then moves to RUN. If the last transfer is at edge T, core_resetn and boot_done rise at edge T+1+RELEASE_DLY.
  - RUN: core_resetn=1, boot_done=1, load_ready=0. Loader inputs are ignored. RUN is absorbing until resetn.
  - ERROR: load_ready=0, core_resetn=0. ERROR is absorbing until resetn.
- Fetch path is combinational (single-cycle core):
  - fetch_instr = mem[fetch_addr] when fetch_addr < count.
  - Otherwise fetch_instr = HALT_INSTR (32'hFC00_0000, opcode 6'b111111). This also covers the period immediately after reset, when count=0.
- Fetch stays functional in every state. Writes during LOAD are visible on the next cycle.
- Reset mid-load: the partial program is discarded logically (count=0). A full reload is then required.
- load_last on the very first word is legal, giving a one-word program.
- Without BOOT_CSUM_EN: exp_csum is ignored and csum_err is tied to 0.

Optional Feature:
- Macro: BOOT_CSUM_EN.
- When defined:
  - Each accepted word is XORed into a 32-bit accumulator.
  - On the load_last transfer, (accumulator ^ load_data) is compared with exp_csum sampled in that same cycle.
  - Mismatch → csum_err←1, state → ERROR; the core is never released.
  - Match → RELEASE as normal.
- When undefined: no accumulator logic, csum_err=0, behaviour exactly as in Behaviour.

Decomposition:
- Package boot_pkg holds:
  - the state enum {IDLE, LOAD, RELEASE, RUN, ERROR};
  - HALT_INSTR = 32'hFC00_0000;
  - OPC_HALT = 6'b111111.
- One natural sub-module: imem_array, DEPTH×32 storage with synchronous write and asynchronous read. The FSM, counters and checksum stay in the top level.

Test Plan:
- Program load:
  - Stimulus: load 0x9000000A, 0x90010004, 0x040117FF, 0xFC000000 back-to-back, last on the 4th word.
  - Response: load_ready low the next cycle; core_resetn and boot_done high exactly 1+RELEASE_DLY=3 edges after the last transfer; fetch_addr=2 returns 0x040117FF; fetch_addr=7 returns 0xFC000000.
- Gapped valid:
  - Stimulus: 3 words with load_valid toggling 1,0,1,0,1 (last on the 3rd valid).
  - Response: exactly 3 writes; fetch 0..2 return the words; fetch 3 returns HALT.
- Overflow:
  - Stimulus: 16 words, never last.
  - Response: after the 16th transfer, overflow_err=1, load_ready=0, core_resetn stays 0 for 20 further cycles; a 17th valid is not accepted.
- Reset mid-load:
  - Stimulus: resetn low after 2 words.
  - Response: core_resetn=0 and load_ready=0 immediately, without waiting for a clock; fetch 0 returns 0xFC000000; reloading a 1-word program 0x12345678 gives fetch 0 = 0x12345678 and the core released.
- Reset during RUN:
  - Stimulus: reach RUN, then pulse resetn.
  - Response: core_resetn drops asynchronously; boot_done=0; state returns to IDLE then LOAD.
- BOOT_CSUM_EN:
  - Stimulus: words 0x1, 0x2, 0x4 with exp_csum=0x7 → RUN.
  - Stimulus: the same words with exp_csum=0x6 → csum_err=1, ERROR, core_resetn held 0.
